// File: rtl/ssp_host_seq.sv
// ssp_host_seq: stages host TX bytes and RX read requests and
// sequences them onto a single-master SSP bus port.
module ssp_host_seq #(
    parameter int TX_DEPTH = 4,
    parameter int CNT_W    = 16
) (
    input  logic             PCLK,
    input  logic             CLEAR_B,
    input  logic [7:0]       i_TX_DATA,
    input  logic             i_TX_VALID,
    output logic             o_TX_READY,
    input  logic             i_RD_REQ,
    output logic [7:0]       o_RX_DATA,
    output logic             o_RX_VALID,
    input  logic             i_RX_READY,
    output logic             o_PSEL,
    output logic             o_PWRITE,
    output logic [7:0]       o_PWDATA,
    input  logic [7:0]       i_PRDATA,
    input  logic             i_SSPTXINTR,
    input  logic             i_SSPRXINTR,
    output logic [CNT_W-1:0] o_TX_CNT,
    output logic [CNT_W-1:0] o_RX_CNT
);

    localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CAPTURE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [7:0]        r_mem [TX_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    logic [3:0]        r_pend;
    logic              r_last_rd;
    logic              w_rd_el;
    logic              w_wr_el;
    logic              w_grant_rd;
    logic              w_grant_wr;
    logic              w_pend_dec;

    logic [7:0]        r_pwdata;
    logic [7:0]        r_rx_data;
    logic              r_rx_valid;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [CNT_W-1:0]  r_rx_cnt;

    // The extra pointer bit tells a full FIFO from an empty one.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop in WRITE frees a slot, so a full FIFO may still accept.
    assign w_pop      = (r_state == S_WRITE);
    assign o_TX_READY = CLEAR_B && (!w_full || w_pop);
    assign w_push     = i_TX_VALID && o_TX_READY;

    assign w_rd_el    = ((r_pend != 4'd0) || i_SSPRXINTR) && !r_rx_valid;
    assign w_wr_el    = !w_empty && !i_SSPTXINTR;
    assign w_pend_dec = w_grant_rd && (r_pend != 4'd0);

    assign o_PWDATA   = r_pwdata;
    assign o_RX_DATA  = r_rx_data;
    assign o_RX_VALID = r_rx_valid;
    assign o_TX_CNT   = r_tx_cnt;
    assign o_RX_CNT   = r_rx_cnt;

    // FIFO storage; contents are qualified by the pointers.
    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_TX_DATA;
        end
    end

    // FIFO pointers.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Pending-read counter: saturating, holds on inc/dec collision.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_pend <= 4'd0;
        end else if (i_RD_REQ && !w_pend_dec) begin
            if (r_pend != 4'hF) begin
                r_pend <= r_pend + 4'd1;
            end
        end else if (w_pend_dec && !i_RD_REQ) begin
            r_pend <= r_pend - 4'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Arbitration, next state and bus strobes.
    always_comb begin
        w_next     = r_state;
        w_grant_rd = 1'b0;
        w_grant_wr = 1'b0;
        o_PSEL     = 1'b0;
        o_PWRITE   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rd_el &&
                    (i_SSPRXINTR || !w_wr_el || !r_last_rd)) begin
                    w_grant_rd = 1'b1;
                    w_next     = S_READ;
                end else if (w_wr_el) begin
                    w_grant_wr = 1'b1;
                    w_next     = S_WRITE;
                end
            end
            S_WRITE: begin
                o_PSEL   = 1'b1;
                o_PWRITE = 1'b1;
                w_next   = S_IDLE;
            end
            S_READ: begin
                o_PSEL = 1'b1;
                w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Write data latch, last-grant memory and TX byte count.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_pwdata  <= 8'h00;
            r_last_rd <= 1'b1;
            r_tx_cnt  <= '0;
        end else begin
            if (w_grant_wr) begin
                r_pwdata  <= r_mem[r_rd_ptr[AW-1:0]];
                r_last_rd <= 1'b0;
            end else if (w_grant_rd) begin
                r_last_rd <= 1'b1;
            end
            if (w_pop) begin
                r_tx_cnt <= r_tx_cnt + CNT_W'(1);
            end
        end
    end

    // RX capture register with valid/ready hold.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_rx_cnt   <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_rx_data  <= i_PRDATA;
            r_rx_valid <= 1'b1;
            r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
        end else if (r_rx_valid && i_RX_READY) begin
            r_rx_valid <= 1'b0;
        end
    end

endmodule
